// File: rtl/rr_arbiter4_pkg.sv
// Shared types and constants for the 4-way round-robin arbiter.
// rr_pick() holds the rotating-priority search so the FSM stays readable.
package rr_arbiter4_pkg;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;
    localparam int CNT_W   = 8;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Returns a one-hot pick of the first set request at ptr, ptr+1, ... (mod NUM_REQ).
    // Walking from the farthest candidate back to ptr lets the nearest one win.
    function automatic logic [NUM_REQ-1:0] rr_pick(
        input logic [NUM_REQ-1:0] req,
        input logic [IDX_W-1:0]   ptr
    );
        logic [NUM_REQ-1:0] pick;
        logic [IDX_W-1:0]   idx;
        pick = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = ptr + IDX_W'(k);
            if (req[idx]) begin
                pick      = '0;
                pick[idx] = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_arbiter4_onehot_enc4.sv
// 4-bit one-hot to 2-bit binary encoder; all-zero input encodes to 2'b00.
module onehot_enc4
    import rr_arbiter4_pkg::*;
(
    input  logic [NUM_REQ-1:0] in_onehot,
    output logic [IDX_W-1:0]   out_idx
);

    // Each output bit is the OR of the input positions whose index has that bit set.
    for (genvar gi = 0; gi < IDX_W; gi++) begin : g_bit
        logic [NUM_REQ-1:0] sel;
        for (genvar gj = 0; gj < NUM_REQ; gj++) begin : g_sel
            localparam bit USE = ((gj >> gi) & 1) == 1;
            assign sel[gj] = USE ? in_onehot[gj] : 1'b0;
        end
        assign out_idx[gi] = |sel;
    end

endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with a bounded hold time and a mandatory
// one-cycle idle bubble between consecutive grants.
module rr_arbiter4
    import rr_arbiter4_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic               grant_vld,
    output logic [IDX_W-1:0]   grant_idx
);

    localparam logic [CNT_W-1:0] MAX_HOLD_C = CNT_W'(MAX_HOLD);

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]   ptr_q,   ptr_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    grant_d = rr_pick(req, ptr_q);
                    cnt_d   = CNT_W'(1);
                    state_d = GRANT;
                end
            end
            GRANT: begin
                // Only the granted line is looked at here; other requests wait for IDLE.
                if (!req[grant_idx] || (cnt_q == MAX_HOLD_C)) begin
                    state_d = IDLE;
                    grant_d = '0;
                    ptr_d   = grant_idx + IDX_W'(1);
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    assign grant     = grant_q;
    assign grant_vld = |grant_q;

    onehot_enc4 u_enc (
        .in_onehot (grant_q),
        .out_idx   (grant_idx)
    );

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed bench for rr_arbiter4: one MAX_HOLD=8 instance and one MAX_HOLD=1 instance.
module tb_rr_arbiter4;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] req1;
    logic [3:0] grant;
    logic [3:0] grant1;
    logic       grant_vld;
    logic       grant_vld1;
    logic [1:0] grant_idx;
    logic [1:0] grant_idx1;

    int errors = 0;
    int checks = 0;

    rr_arbiter4 #(.MAX_HOLD(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .grant     (grant),
        .grant_vld (grant_vld),
        .grant_idx (grant_idx)
    );

    rr_arbiter4 #(.MAX_HOLD(1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req1),
        .grant     (grant1),
        .grant_vld (grant_vld1),
        .grant_idx (grant_idx1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [1:0] enc(input logic [3:0] g);
        case (g)
            4'b0010: return 2'd1;
            4'b0100: return 2'd2;
            4'b1000: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    // Advance one cycle, sample on the falling edge, and check output consistency of both instances.
    task automatic step();
        @(negedge clk);
        checks++;
        if ($countones(grant) > 1 || grant_vld !== (|grant) || grant_idx !== enc(grant)) begin
            errors++;
            $display("FAIL invariant_dut: grant=%b vld=%b idx=%0d", grant, grant_vld, grant_idx);
        end
        checks++;
        if ($countones(grant1) > 1 || grant_vld1 !== (|grant1) || grant_idx1 !== enc(grant1)) begin
            errors++;
            $display("FAIL invariant_dut1: grant=%b vld=%b idx=%0d", grant1, grant_vld1, grant_idx1);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 4'b0000;
        req1  = 4'b0000;
        step();
        step();
        checks++;
        if (grant !== 4'b0000 || grant_vld !== 1'b0 || grant_idx !== 2'd0) begin
            errors++;
            $display("FAIL reset_dut: grant=%b vld=%b idx=%0d expected 0000/0/0", grant, grant_vld, grant_idx);
        end
        checks++;
        if (grant1 !== 4'b0000 || grant_vld1 !== 1'b0 || grant_idx1 !== 2'd0) begin
            errors++;
            $display("FAIL reset_dut1: grant=%b vld=%b idx=%0d expected 0000/0/0", grant1, grant_vld1, grant_idx1);
        end
    endtask

    task automatic test_hold();
        rst_n = 1'b1;
        req   = 4'b0100;
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if (grant !== 4'b0100) begin
                errors++;
                $display("FAIL hold cycle %0d: grant=%b expected 0100", i, grant);
            end
            if (i == 0) begin
                checks++;
                if (grant_idx !== 2'd2 || grant_vld !== 1'b1) begin
                    errors++;
                    $display("FAIL hold_idx: idx=%0d vld=%b expected 2/1", grant_idx, grant_vld);
                end
            end
        end
        step();
        checks++;
        if (grant !== 4'b0000) begin
            errors++;
            $display("FAIL hold_bubble: grant=%b expected 0000", grant);
        end
        step();
        checks++;
        if (grant !== 4'b0100) begin
            errors++;
            $display("FAIL hold_regrant: grant=%b expected 0100", grant);
        end
        req = 4'b0000;
        step();
        checks++;
        if (grant !== 4'b0000) begin
            errors++;
            $display("FAIL hold_release: grant=%b expected 0000", grant);
        end
        step();
    endtask

    task automatic test_rotate();
        logic [3:0] exp;
        rst_n = 1'b0;
        req   = 4'b0000;
        step();
        rst_n = 1'b1;
        req   = 4'b1111;
        for (int r = 0; r < 5; r++) begin
            exp = 4'b0001 << (r % 4);
            for (int c = 0; c < 8; c++) begin
                step();
                checks++;
                if (grant !== exp) begin
                    errors++;
                    $display("FAIL rotate grant %0d cycle %0d: grant=%b expected %b", r, c, grant, exp);
                end
            end
            if (r == 4) req = 4'b0000;
            step();
            checks++;
            if (grant !== 4'b0000) begin
                errors++;
                $display("FAIL rotate_bubble %0d: grant=%b expected 0000", r, grant);
            end
        end
    endtask

    task automatic test_drop();
        req = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (grant !== 4'b0010) begin
                errors++;
                $display("FAIL drop_hold cycle %0d: grant=%b expected 0010", i, grant);
            end
        end
        req = 4'b0000;
        step();
        checks++;
        if (grant !== 4'b0000) begin
            errors++;
            $display("FAIL drop_end: grant=%b expected 0000", grant);
        end
        req = 4'b0011;
        step();
        checks++;
        if (grant !== 4'b0001 || grant_idx !== 2'd0) begin
            errors++;
            $display("FAIL drop_wrap: grant=%b idx=%0d expected 0001/0", grant, grant_idx);
        end
        req = 4'b0000;
        step();
        checks++;
        if (grant !== 4'b0000) begin
            errors++;
            $display("FAIL drop_release: grant=%b expected 0000", grant);
        end
    endtask

    task automatic test_ignore();
        req = 4'b0001;
        step();
        checks++;
        if (grant !== 4'b0001) begin
            errors++;
            $display("FAIL ignore_start: grant=%b expected 0001", grant);
        end
        req = 4'b1111;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (grant !== 4'b0001) begin
                errors++;
                $display("FAIL ignore_hold cycle %0d: grant=%b expected 0001", i, grant);
            end
        end
        req = 4'b1110;
        step();
        checks++;
        if (grant !== 4'b0000) begin
            errors++;
            $display("FAIL ignore_end: grant=%b expected 0000", grant);
        end
        step();
        checks++;
        if (grant !== 4'b0010) begin
            errors++;
            $display("FAIL ignore_next: grant=%b expected 0010", grant);
        end
        req = 4'b0000;
        step();
        checks++;
        if (grant !== 4'b0000) begin
            errors++;
            $display("FAIL ignore_release: grant=%b expected 0000", grant);
        end
    endtask

    task automatic test_reset_mid();
        req = 4'b1000;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (grant !== 4'b1000) begin
                errors++;
                $display("FAIL rstmid_grant cycle %0d: grant=%b expected 1000", i, grant);
            end
        end
        rst_n = 1'b0;
        step();
        checks++;
        if (grant !== 4'b0000 || grant_vld !== 1'b0 || grant_idx !== 2'd0) begin
            errors++;
            $display("FAIL rstmid_drop: grant=%b vld=%b idx=%0d expected 0000/0/0", grant, grant_vld, grant_idx);
        end
        rst_n = 1'b1;
        req   = 4'b1001;
        step();
        checks++;
        if (grant !== 4'b0001) begin
            errors++;
            $display("FAIL rstmid_ptr: grant=%b expected 0001", grant);
        end
        req = 4'b0000;
        step();
        checks++;
        if (grant !== 4'b0000) begin
            errors++;
            $display("FAIL rstmid_release: grant=%b expected 0000", grant);
        end
    endtask

    task automatic test_max_hold1();
        logic [3:0] exp;
        req1 = 4'b0010;
        for (int i = 0; i < 8; i++) begin
            step();
            exp = (i % 2 == 0) ? 4'b0010 : 4'b0000;
            checks++;
            if (grant1 !== exp) begin
                errors++;
                $display("FAIL maxhold1 cycle %0d: grant=%b expected %b", i, grant1, exp);
            end
        end
        req1 = 4'b0000;
        step();
        step();
        checks++;
        if (grant1 !== 4'b0000) begin
            errors++;
            $display("FAIL maxhold1_release: grant=%b expected 0000", grant1);
        end
    endtask

    initial begin
        test_reset();
        test_hold();
        test_rotate();
        test_drop();
        test_ignore();
        test_reset_mid();
        test_max_hold1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
